// File: rtl/ecc_ladder_ctrl.sv
// Purpose : Montgomery-ladder sequencer for GF(2^163) Lopez-Dahab scalar multiply; issues one field micro-op at a time.
// Latency : cmd_valid one cycle after start (or after SCAN); next op the cycle after rsp_valid; done one cycle after last rsp_valid.
// Backpr. : cmd_* held stable while cmd_valid && !cmd_ready; nothing advances until the accepted op reports rsp_valid.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, k                      begin multiply with scalar k (sampled in IDLE only)
//   busy, done, inf               busy from start to done; done one-cycle pulse; inf set when k==0
//   bit_idx                       key bit under processing
//   cmd_valid/cmd_ready           micro-op request handshake
//   cmd_op, cmd_dst, cmd_src1/2   op code and register indices
//   rsp_valid                     accepted op has written back
//
// Build option: define ECC_LEADZERO_SKIP_EN to scan for the key MSB and start
// the ladder from (P, 2P) just below it (not constant time). Default build
// processes every key bit from (O, P).

module ecc_ladder_ctrl #(
    parameter int KW = 163
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k,
    output logic          busy,
    output logic          done,
    output logic          inf,
    output logic [7:0]    bit_idx,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [2:0]    cmd_op,
    output logic [2:0]    cmd_dst,
    output logic [2:0]    cmd_src1,
    output logic [2:0]    cmd_src2,
    input  logic          rsp_valid
);

    // FSM states
    localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef ECC_LEADZERO_SKIP_EN
    localparam logic [2:0] S_SCAN  = 3'd1;
`endif
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Sequence phases
    localparam logic [1:0] PH_INIT = 2'd0;
    localparam logic [1:0] PH_LAD  = 2'd1;
    localparam logic [1:0] PH_CONV = 2'd2;

    // Op codes
    localparam logic [2:0] OP_MUL = 3'd0;
    localparam logic [2:0] OP_SQR = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_MOV = 3'd3;
    localparam logic [2:0] OP_LD1 = 3'd4;
    localparam logic [2:0] OP_INV = 3'd5;
`ifndef ECC_LEADZERO_SKIP_EN
    localparam logic [2:0] OP_LD0 = 3'd6;
`endif

    // Register file indices
    localparam logic [2:0] R_X1 = 3'd0;
    localparam logic [2:0] R_Z1 = 3'd1;
    localparam logic [2:0] R_X2 = 3'd2;
    localparam logic [2:0] R_Z2 = 3'd3;
    localparam logic [2:0] R_T1 = 3'd4;
    localparam logic [2:0] R_T2 = 3'd5;
    localparam logic [2:0] R_XP = 3'd6;
    localparam logic [2:0] R_B  = 3'd7;

`ifdef ECC_LEADZERO_SKIP_EN
    localparam logic [3:0] INIT_LAST = 4'd4;
`else
    localparam logic [3:0] INIT_LAST = 4'd3;
`endif
    localparam logic [3:0] LAD_LAST  = 4'd14;
    localparam logic [3:0] CONV_LAST = 4'd1;
    localparam logic [7:0] TOP_BIT   = 8'(KW - 1);

    logic [2:0]    state;
    logic [1:0]    phase;
    logic [3:0]    op_idx;
    logic [KW-1:0] k_reg;
`ifdef ECC_LEADZERO_SKIP_EN
    // MSB found at bit 0: there are no ladder steps after the (P, 2P) init.
    logic          no_ladder;
`endif

    logic          kbit;
    logic [2:0]    xa, za, xd, zd;
    logic [11:0]   cmd;

    function automatic logic [11:0] pack(input logic [2:0] op, input logic [2:0] dst,
                                         input logic [2:0] s1, input logic [2:0] s2);
        return {op, dst, s1, s2};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= PH_INIT;
            op_idx    <= 4'd0;
            k_reg     <= '0;
            bit_idx   <= TOP_BIT;
            inf       <= 1'b0;
`ifdef ECC_LEADZERO_SKIP_EN
            no_ladder <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_reg   <= k;
                        inf     <= (k == '0);
                        bit_idx <= TOP_BIT;
                        phase   <= PH_INIT;
                        op_idx  <= 4'd0;
                        if (k == '0) begin
                            state <= S_DONE;
                        end else begin
`ifdef ECC_LEADZERO_SKIP_EN
                            state <= S_SCAN;
`else
                            state <= S_ISSUE;
`endif
                        end
                    end
                end
`ifdef ECC_LEADZERO_SKIP_EN
                S_SCAN: begin
                    // k_reg is nonzero here, so a set bit is always found.
                    if (k_reg[bit_idx]) begin
                        state     <= S_ISSUE;
                        no_ladder <= (bit_idx == 8'd0);
                        if (bit_idx != 8'd0) begin
                            bit_idx <= bit_idx - 8'd1;
                        end
                    end else begin
                        bit_idx <= bit_idx - 8'd1;
                    end
                end
`endif
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        state <= S_ISSUE;
                        case (phase)
                            PH_INIT: begin
                                if (op_idx == INIT_LAST) begin
                                    op_idx <= 4'd0;
`ifdef ECC_LEADZERO_SKIP_EN
                                    if (no_ladder) begin
                                        phase   <= PH_CONV;
                                        bit_idx <= bit_idx - 8'd1;
                                    end else begin
                                        phase <= PH_LAD;
                                    end
`else
                                    phase <= PH_LAD;
`endif
                                end else begin
                                    op_idx <= op_idx + 4'd1;
                                end
                            end
                            PH_LAD: begin
                                if (op_idx == LAD_LAST) begin
                                    op_idx <= 4'd0;
                                    // Bit 0 done: the wrap to 255 only happens on entry to conversion.
                                    bit_idx <= bit_idx - 8'd1;
                                    if (bit_idx == 8'd0) begin
                                        phase <= PH_CONV;
                                    end
                                end else begin
                                    op_idx <= op_idx + 4'd1;
                                end
                            end
                            PH_CONV: begin
                                if (op_idx == CONV_LAST) begin
                                    op_idx <= 4'd0;
                                    state  <= S_DONE;
                                end else begin
                                    op_idx <= op_idx + 4'd1;
                                end
                            end
                            default: begin
                                phase <= PH_INIT;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Role mapping: key bit 1 adds into (X1,Z1) and doubles (X2,Z2); bit 0 swaps.
    assign kbit = k_reg[bit_idx];
    assign xa   = kbit ? R_X1 : R_X2;
    assign za   = kbit ? R_Z1 : R_Z2;
    assign xd   = kbit ? R_X2 : R_X1;
    assign zd   = kbit ? R_Z2 : R_Z1;

    always_comb begin
        cmd = '0;
        if (state == S_ISSUE) begin
            case (phase)
                PH_INIT: begin
                    case (op_idx)
`ifdef ECC_LEADZERO_SKIP_EN
                        4'd0:    cmd = pack(OP_MOV, R_X1, R_XP, R_XP);
                        4'd1:    cmd = pack(OP_LD1, R_Z1, 3'd0, 3'd0);
                        4'd2:    cmd = pack(OP_SQR, R_Z2, R_XP, R_XP);
                        4'd3:    cmd = pack(OP_SQR, R_X2, R_Z2, R_Z2);
                        4'd4:    cmd = pack(OP_ADD, R_X2, R_X2, R_B);
`else
                        4'd0:    cmd = pack(OP_LD1, R_X1, 3'd0, 3'd0);
                        4'd1:    cmd = pack(OP_LD0, R_Z1, 3'd0, 3'd0);
                        4'd2:    cmd = pack(OP_MOV, R_X2, R_XP, R_XP);
                        4'd3:    cmd = pack(OP_LD1, R_Z2, 3'd0, 3'd0);
`endif
                        default: cmd = '0;
                    endcase
                end
                PH_LAD: begin
                    case (op_idx)
                        // differential add into (Xa, Za)
                        4'd0:    cmd = pack(OP_MUL, R_T1, xa, zd);
                        4'd1:    cmd = pack(OP_MUL, xa, xd, za);
                        4'd2:    cmd = pack(OP_ADD, za, R_T1, xa);
                        4'd3:    cmd = pack(OP_MUL, xa, R_T1, xa);
                        4'd4:    cmd = pack(OP_SQR, za, za, za);
                        4'd5:    cmd = pack(OP_MUL, R_T1, R_XP, za);
                        4'd6:    cmd = pack(OP_ADD, xa, xa, R_T1);
                        // doubling of (Xd, Zd)
                        4'd7:    cmd = pack(OP_SQR, xd, xd, xd);
                        4'd8:    cmd = pack(OP_SQR, zd, zd, zd);
                        4'd9:    cmd = pack(OP_MUL, R_T2, xd, zd);
                        4'd10:   cmd = pack(OP_SQR, xd, xd, xd);
                        4'd11:   cmd = pack(OP_SQR, zd, zd, zd);
                        4'd12:   cmd = pack(OP_MUL, zd, R_B, zd);
                        4'd13:   cmd = pack(OP_ADD, xd, xd, zd);
                        4'd14:   cmd = pack(OP_MOV, zd, R_T2, R_T2);
                        default: cmd = '0;
                    endcase
                end
                PH_CONV: begin
                    if (op_idx == 4'd0) begin
                        cmd = pack(OP_INV, R_T1, R_Z1, R_Z1);
                    end else begin
                        cmd = pack(OP_MUL, R_X1, R_X1, R_T1);
                    end
                end
                default: cmd = '0;
            endcase
        end
    end

    assign {cmd_op, cmd_dst, cmd_src1, cmd_src2} = cmd;
    assign cmd_valid = (state == S_ISSUE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

endmodule
